// File: rtl/latch_exerciser.sv
// Stimulus/check sequencer for an external gated D latch: applies 8 fixed (cp,d) steps and scores Q.
// Optional: define LATCH_EXER_QN_CHK_EN to also require the synchronized /Q to be the complement of Q.
module latch_exerciser #(
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       d_out,
  output logic       cp_out,
  input  logic       q_in,
  input  logic       qn_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_cnt,
  output logic [2:0] first_fail_idx,
  output logic [2:0] step_idx
);

  // state   | meaning
  // IDLE    | waiting for the first start edge after reset
  // CP_LOW  | close the latch gate before moving D
  // D_SET   | drive the step's D value with the gate closed
  // CP_SET  | drive the step's gate value
  // SETTLE  | wait SETTLE_CYC cycles for latch + synchronizer
  // CHECK   | score synchronized Q against the expected value
  // DONE    | result held; a start edge begins a new run
  typedef enum logic [2:0] {
    IDLE, CP_LOW, D_SET, CP_SET, SETTLE, CHECK, DONE
  } state_t;

  // Bit i of each table is the value for step i.
  localparam logic [7:0] STEP_CP = 8'b0100_1011;
  localparam logic [7:0] STEP_D  = 8'b1010_1101;
  localparam logic [7:0] STEP_Q  = 8'b0011_1001;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] fail_cnt_q, fail_cnt_d;
  logic [2:0] first_fail_q, first_fail_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       d_out_q, d_out_d;
  logic       cp_out_q, cp_out_d;
  logic       start_prev_q, start_prev_d;
  logic       q_s1_q, q_s1_d;
  logic       q_s2_q, q_s2_d;
  logic       start_edge;
  logic       accept;
  logic       step_fail;

`ifdef LATCH_EXER_QN_CHK_EN
  logic qn_s1_q, qn_s1_d;
  logic qn_s2_q, qn_s2_d;

  always_comb begin
    qn_s1_d = qn_in;
    qn_s2_d = qn_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qn_s1_q <= 1'b0;
      qn_s2_q <= 1'b0;
    end else begin
      qn_s1_q <= qn_s1_d;
      qn_s2_q <= qn_s2_d;
    end
  end

  // A step fails once even if both Q and /Q are wrong.
  assign step_fail = (q_s2_q != STEP_Q[step_q]) || (qn_s2_q == q_s2_q);
`else
  logic qn_unused;
  assign qn_unused = qn_in;
  assign step_fail = (q_s2_q != STEP_Q[step_q]);
`endif

  always_comb begin
    q_s1_d       = q_in;
    q_s2_d       = q_s1_q;
    start_prev_d = start;
  end

  assign start_edge = start & ~start_prev_q;
  assign accept     = start_edge && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    settle_d     = settle_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d      = CP_LOW;
          step_d       = 3'd0;
          fail_cnt_d   = 4'd0;
          first_fail_d = 3'd0;
        end
      end
      CP_LOW: state_d = D_SET;
      D_SET:  state_d = CP_SET;
      CP_SET: begin
        state_d  = SETTLE;
        settle_d = SETTLE_LOAD;
      end
      SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CHECK: begin
        if (step_fail) begin
          fail_cnt_d = fail_cnt_q + 4'd1;
          if (fail_cnt_q == 4'd0) begin
            first_fail_d = step_q;
          end
        end
        if (step_q == 3'd7) begin
          state_d = DONE;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = CP_LOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drive outputs change on the edge that enters a state, keyed off next state/step,
  // so D and CP always move in different cycles.
  always_comb begin
    d_out_d  = d_out_q;
    cp_out_d = cp_out_q;
    case (state_d)
      CP_LOW:  cp_out_d = 1'b0;
      D_SET:   d_out_d  = STEP_D[step_d];
      CP_SET:  cp_out_d = STEP_CP[step_d];
      default: ;
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_q == DONE) && !accept;
    pass_d = done_d && (fail_cnt_q == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= 3'd0;
      settle_q     <= 4'd0;
      fail_cnt_q   <= 4'd0;
      first_fail_q <= 3'd0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      d_out_q      <= 1'b0;
      cp_out_q     <= 1'b0;
      start_prev_q <= 1'b0;
      q_s1_q       <= 1'b0;
      q_s2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      settle_q     <= settle_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      d_out_q      <= d_out_d;
      cp_out_q     <= cp_out_d;
      start_prev_q <= start_prev_d;
      q_s1_q       <= q_s1_d;
      q_s2_q       <= q_s2_d;
    end
  end

  assign d_out          = d_out_q;
  assign cp_out         = cp_out_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = first_fail_q;
  assign step_idx       = step_q;

endmodule

// File: tb/tb_latch_exerciser.sv
// Directed bench for latch_exerciser with a behavioural gated D latch and fault modes on Q//Q.
module tb_latch_exerciser;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       d_out;
  logic       cp_out;
  logic       q_in;
  logic       qn_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_cnt;
  logic [2:0] first_fail_idx;
  logic [2:0] step_idx;

  int tests_run    = 0;
  int tests_failed = 0;
  int toggle_viol  = 0;
  int mode         = 0;  // 0: good latch, 1: Q stuck 0 / QN stuck 1, 2: QN tied to Q

  logic latch_q = 1'b0;
  logic acc_busy, acc_done, acc_pass;
  logic [3:0] acc_fc;
  int   lat;

  latch_exerciser #(.SETTLE_CYC(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .d_out          (d_out),
    .cp_out         (cp_out),
    .q_in           (q_in),
    .qn_in          (qn_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .step_idx       (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_latch begin
    if (cp_out) latch_q = d_out;
  end

  assign q_in  = (mode == 1) ? 1'b0 : latch_q;
  assign qn_in = (mode == 1) ? 1'b1 : (mode == 2) ? latch_q : ~latch_q;

  initial begin
    logic pd, pc;
    pd = 1'b0;
    pc = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (d_out != pd) && (cp_out != pc)) begin
        toggle_viol++;
        $display("FAIL toggle: d_out %0b->%0b and cp_out %0b->%0b in one cycle, required at most one",
                 pd, d_out, pc, cp_out);
      end
      pd = d_out;
      pc = cp_out;
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Pulse (or hold) start, record outputs just after the accepting edge, then count
  // edges until done. inject_at > 0 pulses start again at that cycle of the run.
  task automatic run(input bit hold, input int inject_at, output int n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    acc_busy = busy;
    acc_done = done;
    acc_pass = pass;
    acc_fc   = fail_cnt;
    n = 0;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (inject_at > 0 && n == inject_at) start = 1'b1;
      if (inject_at > 0 && n == inject_at + 2) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || d_out !== 1'b0 || cp_out !== 1'b0 ||
        fail_cnt !== 4'd0 || first_fail_idx !== 3'd0 || step_idx !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%0b done=%0b pass=%0b d=%0b cp=%0b fc=%0d ffi=%0d step=%0d, required all 0",
               busy, done, pass, d_out, cp_out, fail_cnt, first_fail_idx, step_idx);
    end
  endtask

  task automatic test_good_run;
    mode = 0;
    run(1'b0, 0, lat);
    chk("good_busy_at_accept", int'(acc_busy), 1);
    chk("good_latency", lat, 57);
    chk("good_pass", int'(pass), 1);
    chk("good_fail_cnt", int'(fail_cnt), 0);
    chk("good_first_fail", int'(first_fail_idx), 0);
    chk("good_busy_done", int'(busy), 0);
    chk("good_step_final", int'(step_idx), 7);
    chk("good_d_hold", int'(d_out), 1);
    chk("good_cp_hold", int'(cp_out), 0);
  endtask

  task automatic test_stuck_q;
    mode = 1;
    run(1'b0, 0, lat);
    chk("stuck_clear_done", int'(acc_done), 0);
    chk("stuck_clear_pass", int'(acc_pass), 0);
    chk("stuck_latency", lat, 57);
    chk("stuck_fail_cnt", int'(fail_cnt), 4);
    chk("stuck_first_fail", int'(first_fail_idx), 0);
    chk("stuck_pass", int'(pass), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("stuck_done_held", int'(done), 1);
  endtask

  task automatic test_rerun_clears;
    mode = 0;
    run(1'b0, 0, lat);
    chk("rerun_fc_cleared", int'(acc_fc), 0);
    chk("rerun_done_dropped", int'(acc_done), 0);
    chk("rerun_pass", int'(pass), 1);
  endtask

  task automatic test_qn_tied;
    mode = 2;
    run(1'b0, 0, lat);
    chk("qn_latency", lat, 57);
`ifdef LATCH_EXER_QN_CHK_EN
    chk("qn_fail_cnt", int'(fail_cnt), 8);
    chk("qn_pass", int'(pass), 0);
`else
    chk("qn_fail_cnt", int'(fail_cnt), 0);
    chk("qn_pass", int'(pass), 1);
`endif
    mode = 0;
  endtask

  task automatic test_start_held;
    mode = 0;
    run(1'b1, 0, lat);
    chk("held_latency", lat, 57);
    repeat (200 - 57) @(posedge clk);
    #1;
    chk("held_single_run_done", int'(done), 1);
    chk("held_single_run_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("held_release_done", int'(done), 1);
  endtask

  task automatic test_back_to_back;
    mode = 0;
    run(1'b0, 20, lat);
    chk("busy_pulse_latency", lat, 57);
    chk("busy_pulse_pass", int'(pass), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_pulse_no_rerun", int'(busy), 0);
  endtask

  task automatic test_reset_mid_run;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    chk("mid_step_before_reset", int'(step_idx), 4);
    chk("mid_busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_idle_after_release", int'(busy), 0);
    run(1'b0, 0, lat);
    chk("mid_rerun_latency", lat, 57);
    chk("mid_rerun_pass", int'(pass), 1);
    chk("mid_rerun_fail_cnt", int'(fail_cnt), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_good_run;
    test_stuck_q;
    test_rerun_clears;
    test_qn_tied;
    test_start_held;
    test_back_to_back;
    test_reset_mid_run;
    chk("no_same_cycle_toggle", toggle_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/latch_exerciser.md
LATCH_EXERCISER -- requirements
Module: latch_exerciser

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 3, legal range 3..15: cycles waited after driving a vector before sampling the latch.
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, run request (board button); a run begins on its rising edge.
REQ-005 SHALL have port d_out, output, 1, data drive to the gated D latch under test.
REQ-006 SHALL have port cp_out, output, 1, gate/enable drive to the latch under test.
REQ-007 SHALL have ports q_in and qn_in, input, 1 each, latch outputs Q and /Q under test.
REQ-008 SHALL have port busy, output, 1, high while a run is in progress.
REQ-009 SHALL have port done, output, 1, high from run completion until the next run starts.
REQ-010 SHALL have port pass, output, 1, valid while done is high; 1 = zero failing steps.
REQ-011 SHALL have port fail_cnt, output, 4, number of failing steps in the last run (0..8).
REQ-012 SHALL have port first_fail_idx, output, 3, index of the first failing step (0 if none).
REQ-013 SHALL have port step_idx, output, 3, index of the step being applied (LED display).

Function
REQ-014 SHALL pass q_in and qn_in through 2-flop synchronizers before any use.
REQ-015 SHALL detect start as a rising edge (registered previous value); start edges while busy=1 SHALL be ignored.
REQ-016 SHALL apply 8 fixed steps (cp,d -> expected q): 0:(1,1->1) 1:(1,0->0) 2:(0,1->0) 3:(1,1->1) 4:(0,0->1) 5:(0,1->1) 6:(1,0->0) 7:(0,1->0).
REQ-017 SHALL use FSM states IDLE, CP_LOW, D_SET, CP_SET, SETTLE, CHECK, DONE.
REQ-018 IDLE/DONE -> CP_LOW (step 0) on an accepted start edge; fail_cnt, first_fail_idx and pass SHALL clear and done SHALL drop on the same edge.
REQ-019 CP_LOW SHALL drive cp_out=0 with d_out unchanged; D_SET SHALL drive d_out=step d with cp_out=0; CP_SET SHALL drive cp_out=step cp; d and cp SHALL never change in the same cycle.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles, then CHECK for one cycle; each step therefore takes SETTLE_CYC+4 cycles.
REQ-021 CHECK SHALL compare the synchronized q with the expected q; on mismatch fail_cnt SHALL increment and, if it was 0, first_fail_idx SHALL load step_idx.
REQ-022 After CHECK of step 7 SHALL enter DONE with pass=(fail_cnt==0) and remain there; otherwise step_idx SHALL increment and go to CP_LOW.
REQ-023 done SHALL rise 8*(SETTLE_CYC+4)+1 cycles after the edge that accepts start (57 for default).
REQ-024 busy SHALL be 1 in every state except IDLE and DONE; d_out and cp_out SHALL hold their last values in DONE.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, d_out=0, cp_out=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_idx=0, step_idx=0, synchronizers and start-edge register=0.
REQ-026 Reset asserted mid-run SHALL abort the run with no result retained; a start edge after release SHALL begin a fresh run at step 0.

Configuration
REQ-027 With macro LATCH_EXER_QN_CHK_EN defined, CHECK SHALL also fail a step when the synchronized qn != ~q (counted once per step even if q also mismatches).
REQ-028 Without LATCH_EXER_QN_CHK_EN, qn_in SHALL be ignored (synchronizer may be omitted) and only q is checked.

Verification
REQ-029 Correct behavioural latch attached, start pulse -> done=1 at cycle 57, pass=1, fail_cnt=0, first_fail_idx=0.
REQ-030 q_in tied 0, qn_in tied 1 -> fail_cnt=4 (steps 0,3,4,5), first_fail_idx=0, pass=0.
REQ-031 Correct latch but qn_in tied to q_in -> with LATCH_EXER_QN_CHK_EN fail_cnt=8, pass=0; without it fail_cnt=0, pass=1.
REQ-032 start held high for 200 cycles -> exactly one run; second start pulse during busy -> ignored, done still at cycle 57.
REQ-033 rst_n pulsed low during step 4 SETTLE -> all outputs at reset values immediately; new start -> full correct run, pass=1.
REQ-034 Every cycle of every run: bench asserts d_out and cp_out never toggle in the same cycle.
